vproc_mem_arbiter: RTL and testbench

- Two-requester memory arbiter downstream of the vector data cache's memory port.
- Merges two cache-side memory request interfaces (port 0: vector data cache, port 1: second cache / refill client) onto a single memory port.
- Uses grant/rvalid semantics identical to the cache memory interface.
- Locks ownership for whole line transfers and routes in-order responses back to the issuing port via an outstanding-transaction FIFO.

---
 rtl/vproc_mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_vproc_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vproc_mem_arbiter.sv
// vproc_mem_arbiter
//   Two-requester memory arbiter. Merges two cache-side memory request
//   interfaces onto one memory port. Port 0 is the vector data cache and
//   port 1 is a second cache or refill client. Once a port is granted, it
//   keeps ownership until it drops its request, so a full line transfer
//   (for example a spill followed by a fill) stays contiguous. In-order
//   responses are routed back to the issuing port through a small FIFO
//   that stores the port number of each outstanding transaction.
//
//   Optional feature: define VPROC_MEM_ARB_RR_EN to get round-robin
//   arbitration in IDLE. Without it, port 0 has fixed priority.
//
// Ports
//   clk_i, rst_i            clock; synchronous active-high reset
//   req_i/addr_i/we_i/
//   wdata_i                 per-port request (port p at slice p)
//   gnt_o, rvalid_o         per-port grant and response valid
//   rdata_o, err_o          response data/error, shared by both ports
//   hold_o                  per-port hold, asserted for the port locked out
//   spurious_o              one-cycle pulse after a response with no
//                           outstanding transaction
//   mem_*                   single downstream memory port
//
// State | meaning
// IDLE  | no owner; arbitrate between requesting ports
// OWN0  | port 0 owns the memory port until req_i[0] drops
// OWN1  | port 1 owns the memory port until req_i[1] drops

module vproc_mem_arbiter #(
    parameter int unsigned ADDR_BIT_W      = 16,
    parameter int unsigned MEM_BYTE_W      = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [1:0]                  req_i,
    input  logic [2*ADDR_BIT_W-1:0]     addr_i,
    input  logic [1:0]                  we_i,
    input  logic [2*MEM_BYTE_W*8-1:0]   wdata_i,
    output logic [1:0]                  gnt_o,
    output logic [1:0]                  rvalid_o,
    output logic [MEM_BYTE_W*8-1:0]     rdata_o,
    output logic                        err_o,
    output logic [1:0]                  hold_o,
    output logic                        spurious_o,
    output logic                        mem_req_o,
    output logic [ADDR_BIT_W-1:0]       mem_addr_o,
    output logic                        mem_we_o,
    output logic [MEM_BYTE_W*8-1:0]     mem_wdata_o,
    input  logic                        mem_gnt_i,
    input  logic                        mem_rvalid_i,
    input  logic [MEM_BYTE_W*8-1:0]     mem_rdata_i,
    input  logic                        mem_err_i
);

    localparam int unsigned DATA_W = MEM_BYTE_W * 8;
    localparam int unsigned PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               fifo_q [MAX_OUTSTANDING];
    logic               fifo_d [MAX_OUTSTANDING];
    logic               spurious_q, spurious_d;

    logic               both_sel;
    logic               fwd;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               head;

`ifdef VPROC_MEM_ARB_RR_EN
    logic               rr_q, rr_d;
    assign both_sel = rr_q;
`else
    assign both_sel = 1'b0;
`endif

    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign head       = fifo_q[rd_ptr_q];

    // Forwarded port: the owner while locked, otherwise the arbitration winner.
    always_comb begin
        fwd = 1'b0;
        unique case (state_q)
            OWN0: fwd = 1'b0;
            OWN1: fwd = 1'b1;
            default: begin
                unique case (req_i)
                    2'b10:   fwd = 1'b1;
                    2'b11:   fwd = both_sel;
                    default: fwd = 1'b0;
                endcase
            end
        endcase
    end

    // Full is judged on the registered count, so a pop in the same cycle
    // frees a slot only from the next cycle on.
    assign push = req_i[fwd] & mem_gnt_i & ~fifo_full;
    assign pop  = mem_rvalid_i & ~fifo_empty;

    assign mem_req_o   = req_i[fwd] & ~fifo_full;
    assign mem_addr_o  = fwd ? addr_i[2*ADDR_BIT_W-1:ADDR_BIT_W] : addr_i[ADDR_BIT_W-1:0];
    assign mem_we_o    = we_i[fwd];
    assign mem_wdata_o = fwd ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];

    assign gnt_o[0]    = push & ~fwd;
    assign gnt_o[1]    = push & fwd;
    assign rvalid_o[0] = pop & ~head;
    assign rvalid_o[1] = pop & head;
    assign rdata_o     = mem_rdata_i;
    assign err_o       = mem_err_i;
    assign spurious_o  = spurious_q;

    always_comb begin
        hold_o = 2'b00;
        unique case (state_q)
            OWN0:    hold_o = 2'b10;
            OWN1:    hold_o = 2'b01;
            default: hold_o = 2'b00;
        endcase
    end

    // Ownership FSM. Arbitration only happens in IDLE, so a releasing port
    // cannot win again in its release cycle.
    always_comb begin
        state_d = state_q;
`ifdef VPROC_MEM_ARB_RR_EN
        rr_d    = rr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = fwd ? OWN1 : OWN0;
                end
            end
            OWN0: begin
                if (!req_i[0]) begin
                    state_d = IDLE;
`ifdef VPROC_MEM_ARB_RR_EN
                    rr_d    = 1'b1;
`endif
                end
            end
            OWN1: begin
                if (!req_i[1]) begin
                    state_d = IDLE;
`ifdef VPROC_MEM_ARB_RR_EN
                    rr_d    = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response-routing FIFO: one entry (issuing port) per accepted beat.
    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        spurious_d = mem_rvalid_i & fifo_empty;
        if (push) begin
            fifo_d[wr_ptr_q] = fwd;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            spurious_q <= spurious_d;
        end
    end

`ifdef VPROC_MEM_ARB_RR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Entry storage needs no reset: only slots between the pointers are read.
    always_ff @(posedge clk_i) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_vproc_mem_arbiter.sv
module tb_vproc_mem_arbiter;

    localparam int ADDR_BIT_W = 16;
    localparam int MEM_BYTE_W = 4;
    localparam int DW         = MEM_BYTE_W * 8;

`ifdef VPROC_MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [ADDR_BIT_W-1:0] ADDR0  = 16'h0A00;
    localparam logic [ADDR_BIT_W-1:0] ADDR1  = 16'h0B00;
    localparam logic [DW-1:0]         WDATA0 = 32'hAAAA0001;
    localparam logic [DW-1:0]         WDATA1 = 32'hBBBB0001;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [1:0]              req_i;
    logic [2*ADDR_BIT_W-1:0] addr_i;
    logic [1:0]              we_i;
    logic [2*DW-1:0]         wdata_i;
    logic [1:0]              gnt_o;
    logic [1:0]              rvalid_o;
    logic [DW-1:0]           rdata_o;
    logic                    err_o;
    logic [1:0]              hold_o;
    logic                    spurious_o;
    logic                    mem_req_o;
    logic [ADDR_BIT_W-1:0]   mem_addr_o;
    logic                    mem_we_o;
    logic [DW-1:0]           mem_wdata_o;
    logic                    mem_gnt_i;
    logic                    mem_rvalid_i;
    logic [DW-1:0]           mem_rdata_i;
    logic                    mem_err_i;

    vproc_mem_arbiter #(
        .ADDR_BIT_W      (ADDR_BIT_W),
        .MEM_BYTE_W      (MEM_BYTE_W),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .wdata_i      (wdata_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .hold_o       (hold_o),
        .spurious_o   (spurious_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          rst;
        logic [1:0]    req;
        logic [1:0]    we;
        logic          gnt;
        logic          rv;
        logic [DW-1:0] rd;
        logic          err;
        logic [1:0]    e_gnt;
        logic [1:0]    e_rv;
        logic [1:0]    e_hold;
        logic          e_mreq;
        logic          e_port;
        logic          e_we;
        logic          e_spur;
    } vec_t;

    vec_t vecs[$];
    int   tests  = 0;
    int   failed = 0;

    function automatic void add(input logic rst, input logic [1:0] req, input logic [1:0] we,
                                input logic gnt, input logic rv, input logic [DW-1:0] rd,
                                input logic err, input logic [1:0] e_gnt, input logic [1:0] e_rv,
                                input logic [1:0] e_hold, input logic e_mreq, input logic e_port,
                                input logic e_we, input logic e_spur);
        vec_t v;
        v.rst = rst;   v.req = req;     v.we = we;         v.gnt = gnt;
        v.rv = rv;     v.rd = rd;       v.err = err;       v.e_gnt = e_gnt;
        v.e_rv = e_rv; v.e_hold = e_hold; v.e_mreq = e_mreq; v.e_port = e_port;
        v.e_we = e_we; v.e_spur = e_spur;
        vecs.push_back(v);
    endfunction

    function automatic void add_idle(input logic e_spur);
        add(0, 2'b00, 2'b00, 0, 0, '0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, e_spur);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        rst_i        = 1'b0;
        req_i        = 2'b00;
        we_i         = 2'b00;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        mem_err_i    = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   grants;
        bit   seen_full;

        addr_i  = {ADDR1, ADDR0};
        wdata_i = {WDATA1, WDATA0};
        drive_idle();
        rst_i = 1'b1;

        // Reset state
        add_idle(0);
        // Single port 0 fill: 4 reads, memory answers one cycle later
        add(0, 2'b01, 2'b00, 1, 0, 32'h00, 0, 2'b01, 2'b00, 2'b00, 1, 0, 0, 0);
        add(0, 2'b01, 2'b00, 1, 1, 32'h11, 0, 2'b01, 2'b01, 2'b10, 1, 0, 0, 0);
        add(0, 2'b01, 2'b00, 1, 1, 32'h22, 0, 2'b01, 2'b01, 2'b10, 1, 0, 0, 0);
        add(0, 2'b01, 2'b00, 1, 1, 32'h33, 0, 2'b01, 2'b01, 2'b10, 1, 0, 0, 0);
        add(0, 2'b00, 2'b00, 0, 1, 32'h44, 0, 2'b00, 2'b01, 2'b10, 0, 0, 0, 0);
        add_idle(0);
        // Contention after reset: port 0 first, then rr pointer decides
        add(1, 2'b00, 2'b00, 0, 0, 32'h00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        add(0, 2'b11, 2'b00, 1, 0, 32'h00, 0, 2'b01, 2'b00, 2'b00, 1, 0, 0, 0);
        add(0, 2'b11, 2'b00, 1, 1, 32'h55, 0, 2'b01, 2'b01, 2'b10, 1, 0, 0, 0);
        add(0, 2'b10, 2'b00, 1, 1, 32'h66, 0, 2'b00, 2'b01, 2'b10, 0, 0, 0, 0);
        add(0, 2'b11, 2'b00, 1, 0, 32'h00, 0, RR ? 2'b10 : 2'b01, 2'b00, 2'b00, 1, RR, 0, 0);
        add(0, 2'b00, 2'b00, 0, 1, 32'h77, 0, 2'b00, RR ? 2'b10 : 2'b01, RR ? 2'b01 : 2'b10, 0, 0, 0, 0);
        add_idle(0);
        // Backpressure: 4 grants, full blocks, 5th grant one cycle after pop
        add(0, 2'b01, 2'b00, 1, 0, 32'h00, 0, 2'b01, 2'b00, 2'b00, 1, 0, 0, 0);
        add(0, 2'b01, 2'b00, 1, 0, 32'h00, 0, 2'b01, 2'b00, 2'b10, 1, 0, 0, 0);
        add(0, 2'b01, 2'b00, 1, 0, 32'h00, 0, 2'b01, 2'b00, 2'b10, 1, 0, 0, 0);
        add(0, 2'b01, 2'b00, 1, 0, 32'h00, 0, 2'b01, 2'b00, 2'b10, 1, 0, 0, 0);
        add(0, 2'b01, 2'b00, 1, 0, 32'h00, 0, 2'b00, 2'b00, 2'b10, 0, 0, 0, 0);
        add(0, 2'b01, 2'b00, 1, 1, 32'h81, 0, 2'b00, 2'b01, 2'b10, 0, 0, 0, 0);
        add(0, 2'b01, 2'b00, 1, 0, 32'h00, 0, 2'b01, 2'b00, 2'b10, 1, 0, 0, 0);
        add(0, 2'b00, 2'b00, 0, 1, 32'h82, 0, 2'b00, 2'b01, 2'b10, 0, 0, 0, 0);
        add(0, 2'b00, 2'b00, 0, 1, 32'h83, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0);
        add(0, 2'b00, 2'b00, 0, 1, 32'h84, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0);
        add(0, 2'b00, 2'b00, 0, 1, 32'h85, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0);
        add_idle(0);
        // Spill then fill on port 0 while port 1 keeps requesting
        add(1, 2'b00, 2'b00, 0, 0, 32'h00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        add(0, 2'b11, 2'b01, 1, 0, 32'h00, 0, 2'b01, 2'b00, 2'b00, 1, 0, 1, 0);
        add(0, 2'b11, 2'b01, 1, 1, 32'h01, 0, 2'b01, 2'b01, 2'b10, 1, 0, 1, 0);
        add(0, 2'b11, 2'b01, 1, 1, 32'h02, 0, 2'b01, 2'b01, 2'b10, 1, 0, 1, 0);
        add(0, 2'b11, 2'b01, 1, 1, 32'h03, 0, 2'b01, 2'b01, 2'b10, 1, 0, 1, 0);
        add(0, 2'b11, 2'b00, 1, 1, 32'h04, 0, 2'b01, 2'b01, 2'b10, 1, 0, 0, 0);
        add(0, 2'b11, 2'b00, 1, 1, 32'h05, 0, 2'b01, 2'b01, 2'b10, 1, 0, 0, 0);
        add(0, 2'b11, 2'b00, 1, 1, 32'h06, 0, 2'b01, 2'b01, 2'b10, 1, 0, 0, 0);
        add(0, 2'b11, 2'b00, 1, 1, 32'h07, 0, 2'b01, 2'b01, 2'b10, 1, 0, 0, 0);
        add(0, 2'b10, 2'b00, 1, 1, 32'h08, 0, 2'b00, 2'b01, 2'b10, 0, 0, 0, 0);
        add(0, 2'b10, 2'b00, 1, 0, 32'h00, 0, 2'b10, 2'b00, 2'b00, 1, 1, 0, 0);
        add(0, 2'b00, 2'b00, 0, 1, 32'h99, 1, 2'b00, 2'b10, 2'b01, 0, 0, 0, 0);
        add_idle(0);
        // Spurious response with empty FIFO
        add(0, 2'b00, 2'b00, 0, 1, 32'hDEAD, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        add_idle(1);
        add_idle(0);
        // Reset after 2 of 4 grants, then a late response
        add(0, 2'b01, 2'b00, 1, 0, 32'h00, 0, 2'b01, 2'b00, 2'b00, 1, 0, 0, 0);
        add(0, 2'b01, 2'b00, 1, 0, 32'h00, 0, 2'b01, 2'b00, 2'b10, 1, 0, 0, 0);
        add(1, 2'b00, 2'b00, 0, 0, 32'h00, 0, 2'b00, 2'b00, 2'b10, 0, 0, 0, 0);
        add(0, 2'b00, 2'b00, 0, 1, 32'h5A, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        add_idle(1);
        add_idle(0);

        repeat (2) @(posedge clk_i);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            v            = vecs[i];
            rst_i        = v.rst;
            req_i        = v.req;
            we_i         = v.we;
            mem_gnt_i    = v.gnt;
            mem_rvalid_i = v.rv;
            mem_rdata_i  = v.rd;
            mem_err_i    = v.err;
            #4;
            chk($sformatf("v%0d gnt_o", i),      32'(gnt_o),      32'(v.e_gnt));
            chk($sformatf("v%0d rvalid_o", i),   32'(rvalid_o),   32'(v.e_rv));
            chk($sformatf("v%0d hold_o", i),     32'(hold_o),     32'(v.e_hold));
            chk($sformatf("v%0d mem_req_o", i),  32'(mem_req_o),  32'(v.e_mreq));
            chk($sformatf("v%0d spurious_o", i), 32'(spurious_o), 32'(v.e_spur));
            chk($sformatf("v%0d err_o", i),      32'(err_o),      32'(v.err));
            if (v.e_mreq) begin
                chk($sformatf("v%0d mem_addr_o", i), 32'(mem_addr_o), 32'(v.e_port ? ADDR1 : ADDR0));
                chk($sformatf("v%0d mem_we_o", i),   32'(mem_we_o),   32'(v.e_we));
                chk($sformatf("v%0d mem_wdata_o", i), mem_wdata_o,    v.e_port ? WDATA1 : WDATA0);
            end
            if (v.e_rv != 2'b00) begin
                chk($sformatf("v%0d rdata_o", i), rdata_o, v.rd);
            end
            @(posedge clk_i);
            #1;
        end

        // Port 1 burst with responses withheld: must stall after exactly 4 grants
        drive_idle();
        req_i     = 2'b10;
        mem_gnt_i = 1'b1;
        grants    = 0;
        seen_full = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #4;
            if (!mem_req_o) begin
                seen_full = 1'b1;
                break;
            end
            if (gnt_o == 2'b10) grants++;
            @(posedge clk_i);
            #1;
        end
        chk("bp1 stall reached", 32'(seen_full), 32'd1);
        chk("bp1 grant count", 32'(grants), 32'd4);
        chk("bp1 gnt_o when full", 32'(gnt_o), 32'd0);
        @(posedge clk_i);
        #1;
        req_i        = 2'b00;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_rdata_i = 32'hC0 + k;
            #4;
            chk($sformatf("bp1 rvalid_o %0d", k), 32'(rvalid_o), 32'd2);
            chk($sformatf("bp1 rdata_o %0d", k), rdata_o, 32'hC0 + k);
            @(posedge clk_i);
            #1;
        end
        mem_rvalid_i = 1'b0;
        #4;
        chk("bp1 drained rvalid_o", 32'(rvalid_o), 32'd0);
        chk("bp1 drained spurious_o", 32'(spurious_o), 32'd0);
        chk("bp1 released hold_o", 32'(hold_o), 32'd0);
        @(posedge clk_i);
        #1;
        mem_rvalid_i = 1'b1;
        #4;
        chk("bp1 extra rvalid_o", 32'(rvalid_o), 32'd0);
        @(posedge clk_i);
        #1;
        mem_rvalid_i = 1'b0;
        #4;
        chk("bp1 extra spurious_o", 32'(spurious_o), 32'd1);
        @(posedge clk_i);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
